// File: rtl/usb_pkg.sv
// Shared types and constants for the USB host transaction sequencer.
// Latency: none; this package holds only declarations.
// Backpressure: not applicable.
package usb_pkg;

  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;
  localparam int DATA_W = 64;

  // 4-bit PID codes as they appear on the wire
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_DATA,
    ST_WAIT_HS,
    ST_WAIT_DATA,
    ST_SEND_ACK,
    ST_SEND_NAK,
    ST_DONE
  } seq_state_t;

  // Host request captured at txn_start and replayed on every retry
  typedef struct packed {
    logic              is_in;
    logic [ADDR_W-1:0] addr;
    logic [ENDP_W-1:0] endp;
    logic [DATA_W-1:0] wdata;
  } txn_req_t;

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/timeout_timer.sv
// Loadable up-counter with clear; flags expiry when the count reaches LIMIT.
// Latency: o_expired is registered-count compare, valid the cycle the count hits LIMIT.
// Backpressure: none; counting pauses when i_en is low and parks at LIMIT.
module timeout_timer #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  // Clear beats load beats count; the count parks at LIMIT rather than wrapping
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/usb_txn_sequencer.sv
// Host-side USB OUT/IN transaction sequencer with NAK/error/timeout retry; USB_TXN_STATS_EN adds stat counters.
// Latency: token strobe one cycle after txn_start; txn_done one cycle after the deciding handshake or enc_done.
// Backpressure: each packet waits for enc_done; decoder events are held by the decoder until the got_data pulse.
module usb_txn_sequencer
  import usb_pkg::*;
#(
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              txn_start,
  input  logic              txn_is_in,
  input  logic [ADDR_W-1:0] txn_addr,
  input  logic [ENDP_W-1:0] txn_endp,
  input  logic [DATA_W-1:0] txn_wdata,
  output logic              txn_done,
  output logic              txn_ok,
  output logic [DATA_W-1:0] txn_rdata,
  output logic              enc_start,
  output logic [3:0]        enc_pid,
  output logic [ADDR_W-1:0] enc_addr,
  output logic [ENDP_W-1:0] enc_endp,
  output logic [DATA_W-1:0] enc_data,
  input  logic              enc_done,
  input  logic              dec_havepkt,
  input  logic              dec_haveack,
  input  logic              dec_havenak,
  input  logic              dec_error,
  input  logic [3:0]        dec_pid,
  input  logic [DATA_W-1:0] dec_data,
  output logic              got_data
`ifdef USB_TXN_STATS_EN
  ,
  output logic [7:0]        stat_retries,
  output logic [7:0]        stat_fails
`endif
);

  localparam int              ATT_W   = $clog2(MAX_RETRY + 1);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);

  seq_state_t        r_state;
  txn_req_t          r_req;
  logic [ATT_W-1:0]  r_attempt;
  logic              r_enc_start;
  logic [3:0]        r_enc_pid;
  logic [ADDR_W-1:0] r_enc_addr;
  logic [ENDP_W-1:0] r_enc_endp;
  logic [DATA_W-1:0] r_enc_data;
  logic              r_got_data;
  logic              r_txn_done;
  logic              r_txn_ok;
  logic [DATA_W-1:0] r_txn_rdata;

  logic w_in_wait;
  logic w_tmo;
  logic w_dec_any;
  logic w_good_data;
  logic w_last;
  logic w_fail;

  assign w_in_wait   = (r_state == ST_WAIT_HS) || (r_state == ST_WAIT_DATA);
  assign w_dec_any   = dec_haveack || dec_havepkt || dec_havenak || dec_error;
  // ACK outranks a data packet, so a simultaneous ACK spoils the data
  assign w_good_data = !dec_haveack && dec_havepkt && (dec_pid == PID_DATA0);
  assign w_last      = (r_attempt == ATT_MAX);
  // A decoder event always beats a coincident timeout
  assign w_fail      = ((r_state == ST_WAIT_HS) && !dec_haveack && (w_dec_any || w_tmo)) ||
                       ((r_state == ST_SEND_NAK) && enc_done);

  // Held clear outside the wait states, so every entry starts from zero
  timeout_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .rst_L      (rst_L),
    .i_clr      (!w_in_wait),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_in_wait),
    .o_expired  (w_tmo)
  );

  // Transaction FSM; all host, encoder and decoder-side outputs are registered here
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_attempt   <= '0;
      r_enc_start <= 1'b0;
      r_enc_pid   <= '0;
      r_enc_addr  <= '0;
      r_enc_endp  <= '0;
      r_enc_data  <= '0;
      r_got_data  <= 1'b0;
      r_txn_done  <= 1'b0;
      r_txn_ok    <= 1'b0;
      r_txn_rdata <= '0;
    end else begin
      r_enc_start <= 1'b0;
      r_got_data  <= 1'b0;
      r_txn_done  <= 1'b0;
      r_txn_ok    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (txn_start) begin
            r_req       <= '{is_in: txn_is_in, addr: txn_addr, endp: txn_endp, wdata: txn_wdata};
            r_attempt   <= ATT_W'(1);
            r_txn_rdata <= '0;
            r_enc_start <= 1'b1;
            r_enc_pid   <= txn_is_in ? PID_IN : PID_OUT;
            r_enc_addr  <= txn_addr;
            r_enc_endp  <= txn_endp;
            r_enc_data  <= txn_wdata;
            r_state     <= ST_TOKEN;
          end
        end
        ST_TOKEN: begin
          if (enc_done) begin
            if (r_req.is_in) begin
              r_state <= ST_WAIT_DATA;
            end else begin
              r_enc_start <= 1'b1;
              r_enc_pid   <= PID_DATA0;
              r_enc_data  <= r_req.wdata;
              r_state     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (enc_done) r_state <= ST_WAIT_HS;
        end
        ST_WAIT_HS: begin
          if (dec_haveack) begin
            r_got_data <= 1'b1;
            r_txn_done <= 1'b1;
            r_txn_ok   <= 1'b1;
            r_state    <= ST_DONE;
          end else if (w_dec_any) begin
            r_got_data <= 1'b1;
          end
        end
        ST_WAIT_DATA: begin
          if (w_good_data) begin
            r_txn_rdata <= dec_data;
            r_got_data  <= 1'b1;
            r_enc_start <= 1'b1;
            r_enc_pid   <= PID_ACK;
            r_state     <= ST_SEND_ACK;
          end else if (w_dec_any || w_tmo) begin
            r_got_data  <= w_dec_any;
            r_enc_start <= 1'b1;
            r_enc_pid   <= PID_NAK;
            r_state     <= ST_SEND_NAK;
          end
        end
        ST_SEND_ACK: begin
          if (enc_done) begin
            r_txn_done <= 1'b1;
            r_txn_ok   <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_SEND_NAK: begin
          // Completion is a failed attempt, handled below
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // A failed attempt either replays the token or closes the transaction unsuccessfully
      if (w_fail) begin
        if (w_last) begin
          r_txn_done <= 1'b1;
          r_txn_ok   <= 1'b0;
          r_state    <= ST_DONE;
        end else begin
          r_attempt   <= r_attempt + 1'b1;
          r_enc_start <= 1'b1;
          r_enc_pid   <= r_req.is_in ? PID_IN : PID_OUT;
          r_enc_addr  <= r_req.addr;
          r_enc_endp  <= r_req.endp;
          r_enc_data  <= r_req.wdata;
          r_state     <= ST_TOKEN;
        end
      end
    end
  end

  assign txn_done  = r_txn_done;
  assign txn_ok    = r_txn_ok;
  assign txn_rdata = r_txn_rdata;
  assign enc_start = r_enc_start;
  assign enc_pid   = r_enc_pid;
  assign enc_addr  = r_enc_addr;
  assign enc_endp  = r_enc_endp;
  assign enc_data  = r_enc_data;
  assign got_data  = r_got_data;

`ifdef USB_TXN_STATS_EN
  logic [7:0] r_stat_retries;
  logic [7:0] r_stat_fails;

  // Saturating counts of failed attempts and of transactions that ended with ok=0
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_stat_retries <= '0;
      r_stat_fails   <= '0;
    end else if (w_fail) begin
      r_stat_retries <= sat_inc8(r_stat_retries);
      if (w_last) r_stat_fails <= sat_inc8(r_stat_fails);
    end
  end

  assign stat_retries = r_stat_retries;
  assign stat_fails   = r_stat_fails;
`endif

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Randomized bench for usb_txn_sequencer with a scripted encoder/decoder and a per-attempt outcome model.
// Latency: checks packet order, outcome, payloads, handshake counts and timeout spacing per transaction.
// Backpressure: encoder completes after 1-3 cycles; decoder flags are held until got_data.
module tb_usb_txn_sequencer;
  import usb_pkg::*;

  localparam int MAXR = 8;
  localparam int TMO  = 255;
  // Per-attempt device behaviour
  localparam int R_GOOD  = 0;
  localparam int R_NAK   = 1;
  localparam int R_ERR   = 2;
  localparam int R_BAD   = 3;
  localparam int R_NONE  = 4;
  localparam int R_MULTI = 5;

  logic        clk;
  logic        rst_L;
  logic        txn_start, txn_is_in;
  logic [6:0]  txn_addr;
  logic [3:0]  txn_endp;
  logic [63:0] txn_wdata;
  logic        txn_done, txn_ok;
  logic [63:0] txn_rdata;
  logic        enc_start;
  logic [3:0]  enc_pid;
  logic [6:0]  enc_addr;
  logic [3:0]  enc_endp;
  logic [63:0] enc_data;
  logic        enc_done;
  logic        dec_havepkt, dec_haveack, dec_havenak, dec_error;
  logic [3:0]  dec_pid;
  logic [63:0] dec_data;
  logic        got_data;
`ifdef USB_TXN_STATS_EN
  logic [7:0]  stat_retries, stat_fails;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int plan[MAXR];
  int exp_retries = 0;
  int exp_fails   = 0;

  usb_txn_sequencer #(.MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_L(rst_L),
    .txn_start(txn_start), .txn_is_in(txn_is_in), .txn_addr(txn_addr),
    .txn_endp(txn_endp), .txn_wdata(txn_wdata),
    .txn_done(txn_done), .txn_ok(txn_ok), .txn_rdata(txn_rdata),
    .enc_start(enc_start), .enc_pid(enc_pid), .enc_addr(enc_addr),
    .enc_endp(enc_endp), .enc_data(enc_data), .enc_done(enc_done),
    .dec_havepkt(dec_havepkt), .dec_haveack(dec_haveack), .dec_havenak(dec_havenak),
    .dec_error(dec_error), .dec_pid(dec_pid), .dec_data(dec_data),
    .got_data(got_data)
`ifdef USB_TXN_STATS_EN
    , .stat_retries(stat_retries), .stat_fails(stat_fails)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic clear_dec();
    dec_havepkt = 1'b0; dec_haveack = 1'b0; dec_havenak = 1'b0; dec_error = 1'b0;
    dec_pid = 4'h0; dec_data = 64'h0;
  endtask

  task automatic raise_resp(input int r, input logic is_in, input logic [63:0] rd);
    case (r)
      R_GOOD: begin
        if (is_in) begin dec_havepkt = 1'b1; dec_pid = 4'b0011; dec_data = rd; end
        else dec_haveack = 1'b1;
      end
      R_NAK: dec_havenak = 1'b1;
      R_ERR: dec_error = 1'b1;
      R_BAD: begin
        dec_havepkt = 1'b1;
        dec_pid = is_in ? 4'b1011 : 4'b0011;
        dec_data = {$urandom, $urandom};
      end
      default: begin
        // Several flags at once: ACK (OUT) or good DATA0 (IN) must win
        dec_havepkt = 1'b1; dec_pid = 4'b0011; dec_data = rd;
        dec_havenak = 1'b1; dec_error = 1'b1; dec_haveack = !is_in;
      end
    endcase
  endtask

  task automatic check_stats();
`ifdef USB_TXN_STATS_EN
    chk("stat_retries", 64'(stat_retries), 64'(exp_retries));
    chk("stat_fails", 64'(stat_fails), 64'(exp_fails));
`endif
  endtask

  task automatic do_abort();
    #2 rst_L = 1'b0;
    #1;
    chk("rst_enc_start", 64'(enc_start), 64'd0);
    chk("rst_enc_pid", 64'(enc_pid), 64'd0);
    chk("rst_enc_addr", 64'(enc_addr), 64'd0);
    chk("rst_enc_data", enc_data, 64'd0);
    chk("rst_got_data", 64'(got_data), 64'd0);
    chk("rst_txn_done", 64'(txn_done), 64'd0);
    clear_dec();
    enc_done = 1'b0;
    exp_retries = 0;
    exp_fails = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 64'(txn_done), 64'd0);
    end
    check_stats();
    rst_L = 1'b1;
  endtask

  task automatic run_txn(input logic is_in, input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] wd, input logic [63:0] rd, input bit abort);
    logic [3:0]  seen[$];
    logic [3:0]  expq[$];
    logic [3:0]  cur_pid = 4'h0;
    logic [3:0]  tok;
    int          enc_cnt = -1, resp_dly = -1, att = -1, tmo_start = -1;
    int          got_cnt = 0, exp_got = 0, nfail = 0;
    bit          flags_up = 0, done_seen = 0, ok_seen = 0, exp_ok = 0;
    logic [63:0] rdata_seen = 64'h0;
    tok = is_in ? 4'b1001 : 4'b0001;
    // Reference: each attempt is token (+DATA0 for OUT), then the device answer decides
    for (int i = 0; i < MAXR; i++) begin
      expq.push_back(tok);
      if (!is_in) expq.push_back(4'b0011);
      if (plan[i] != R_NONE) exp_got++;
      if (plan[i] == R_GOOD || plan[i] == R_MULTI) begin
        if (is_in) expq.push_back(4'b0010);
        exp_ok = 1;
        break;
      end
      if (is_in) expq.push_back(4'b1010);
      nfail++;
    end

    @(negedge clk);
    txn_start = 1'b1; txn_is_in = is_in; txn_addr = a; txn_endp = e; txn_wdata = wd;
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        txn_start = 1'b0;
        txn_is_in = 1'($urandom_range(0, 1));
        txn_addr = 7'($urandom);
        txn_endp = 4'($urandom);
        txn_wdata = {$urandom, $urandom};
      end
      // Encoder model
      if (enc_done) begin
        enc_done = 1'b0;
        if (cur_pid == 4'b0011 || cur_pid == 4'b1001) begin
          att++;
          if (abort && cur_pid == 4'b0011) begin
            do_abort();
            return;
          end
          if (att >= MAXR || plan[att] == R_NONE) tmo_start = cyc;
          else resp_dly = $urandom_range(0, 3);
        end
      end else if (enc_cnt > 0) begin
        enc_cnt--;
        if (enc_cnt == 0) begin
          chk("pid_hold", 64'(enc_pid), 64'(cur_pid));
          enc_done = 1'b1;
        end
      end
      if (enc_start) begin
        if (tmo_start >= 0) begin
          chk("tmo_gap", 64'((cyc - tmo_start >= TMO) && (cyc - tmo_start <= TMO + 2)), 64'd1);
          tmo_start = -1;
        end
        seen.push_back(enc_pid);
        if (enc_pid == tok) begin
          chk("tok_addr", 64'(enc_addr), 64'(a));
          chk("tok_endp", 64'(enc_endp), 64'(e));
        end
        if (enc_pid == 4'b0011) chk("enc_data", enc_data, wd);
        cur_pid = enc_pid;
        enc_cnt = $urandom_range(1, 3);
      end
      // Decoder model
      if (got_data) begin
        got_cnt++;
        if (flags_up) begin clear_dec(); flags_up = 0; end
      end
      if (resp_dly > 0) resp_dly--;
      else if (resp_dly == 0) begin
        raise_resp(plan[att], is_in, rd);
        flags_up = 1;
        resp_dly = -1;
      end
      if (txn_done) begin
        done_seen = 1; ok_seen = txn_ok; rdata_seen = txn_rdata;
        if (tmo_start >= 0) begin
          chk("tmo_gap_done", 64'((cyc - tmo_start >= TMO) && (cyc - tmo_start <= TMO + 2)), 64'd1);
          tmo_start = -1;
        end
      end
    end
    chk("txn_done", 64'(done_seen), 64'd1);
    chk("txn_ok", 64'(ok_seen), 64'(exp_ok));
    chk("n_pkts", 64'(seen.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < seen.size(); i++)
      chk($sformatf("pkt%0d_pid", i), 64'(seen[i]), 64'(expq[i]));
    chk("got_data_cnt", 64'(got_cnt), 64'(exp_got));
    if (is_in && exp_ok) chk("txn_rdata", rdata_seen, rd);
    clear_dec();
    enc_done = 1'b0;
    @(negedge clk);
    chk("done_pulse", 64'(txn_done), 64'd0);
    exp_retries = (exp_retries + nfail > 255) ? 255 : exp_retries + nfail;
    if (!exp_ok) exp_fails = (exp_fails == 255) ? 255 : exp_fails + 1;
    check_stats();
  endtask

  task automatic set_plan_all(input int r);
    for (int i = 0; i < MAXR; i++) plan[i] = r;
  endtask

  initial begin
    rst_L = 1'b0;
    txn_start = 1'b0; txn_is_in = 1'b0; txn_addr = 7'h0; txn_endp = 4'h0; txn_wdata = 64'h0;
    enc_done = 1'b0;
    clear_dec();
    repeat (3) @(negedge clk);
    chk("reset_enc_start", 64'(enc_start), 64'd0);
    chk("reset_enc_pid", 64'(enc_pid), 64'd0);
    chk("reset_txn_done", 64'(txn_done), 64'd0);
    chk("reset_txn_ok", 64'(txn_ok), 64'd0);
    chk("reset_got_data", 64'(got_data), 64'd0);
    chk("reset_txn_rdata", txn_rdata, 64'd0);
    check_stats();
    rst_L = 1'b1;
    @(negedge clk);

    // OUT success on first try
    set_plan_all(R_GOOD);
    run_txn(1'b0, 7'h05, 4'h4, 64'hDEADBEEF_01234567, 64'h0, 1'b0);
    // IN success
    run_txn(1'b1, 7'h05, 4'h4, 64'h0, 64'hCAFEF00D_00000001, 1'b0);
    // OUT NAK, NAK, ACK
    plan[0] = R_NAK; plan[1] = R_NAK;
    run_txn(1'b0, 7'h22, 4'h1, 64'h11112222_33334444, 64'h0, 1'b0);
    // IN with a silent device: eight timeouts, then failure
    set_plan_all(R_NONE);
    run_txn(1'b1, 7'h33, 4'h7, 64'h0, 64'h0, 1'b0);
    // IN with a corrupt packet, then good data
    set_plan_all(R_GOOD);
    plan[0] = R_ERR;
    run_txn(1'b1, 7'h44, 4'h3, 64'h0, 64'h01020304_05060708, 1'b0);
    // Reset while waiting for the handshake, then a clean transaction
    set_plan_all(R_GOOD);
    run_txn(1'b0, 7'h55, 4'h9, 64'hA5A5A5A5_5A5A5A5A, 64'h0, 1'b1);
    run_txn(1'b0, 7'h66, 4'hA, 64'h0F0F0F0F_F0F0F0F0, 64'h0, 1'b0);

    // Random transactions with mixed device behaviour
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < MAXR; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: plan[i] = R_GOOD;
          3, 8:    plan[i] = R_NAK;
          4, 9:    plan[i] = R_ERR;
          5:       plan[i] = R_BAD;
          6:       plan[i] = R_MULTI;
          default: plan[i] = R_NONE;
        endcase
      end
      run_txn(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
